data8in: RTL and testbench
==========================

Name: data8in

Overview:
Byte-stream receiver that accepts 8-bit bytes qualified by a strobe and reassembles them into an nofBytes-wide word, first byte received placed in the MSBs. It is the receiving end of the byte-serial output link (strobe held high while a byte is valid, low between bytes). It sits on the pclk domain in front of word-wide consumers and flags or drops words that stall mid-transfer.

Parameters:
nofBytes, 3, bytes per assembled word; legal 1..8.
timeout, 15, max clock edges allowed between accepted bytes of one word before the partial word is abandoned; legal 1..255; 0 disables the timeout.

Ports:
pclk  input  1  system clock; all logic on rising edge.
rst  input  1  reset, asynchronous, active-high.
din  input  8  byte data; valid while inputReady is high.
inputReady  input  1  byte strobe from the transmitter; a new byte is signalled by a 0->1 transition.
dout  output  8*nofBytes  last complete word; din of the first byte in dout[8*nofBytes-1:8*nofBytes-8].
ready  output  1  one-cycle pulse: dout has just been updated with a new word.
busy  output  1  high while a partial word is held (COLLECT state).
err  output  1  one-cycle pulse: partial word abandoned on timeout.

Behaviour:
- Reset (async, rst=1): dout=0, ready=0, err=0, busy=0, byte count=0, gap counter=0, state=IDLE, strobe history register=1. Because the history resets to 1, a strobe already high at reset release is not taken as a byte; the next 0->1 transition is.
- Edge detect: history <= inputReady every cycle. A byte is accepted at the edge where inputReady=1 and history=0; din is sampled at that same edge. A strobe held high for any number of cycles yields exactly one byte.
- Shift buffer: 8*(nofBytes-1) bits. Each non-final byte shifts in at the LSB end; earlier bytes move toward the MSB end.
- States:
  IDLE: busy=0. On an accepted byte: if nofBytes=1, dout<=din and ready=1 next cycle, stay IDLE; else store the byte, count=1, gap=0, go to COLLECT.
  COLLECT: busy=1. On an accepted byte: if count=nofBytes-1, dout<={buffer,din}, ready=1 next cycle, count=0, go to IDLE; else shift in, count+1, gap=0. With no accepted byte: gap+1; if timeout!=0 and gap reaches timeout, go to IDLE, count=0, err=1 for one cycle, dout unchanged.
- Latency: ready rises in the cycle immediately after the clock edge that samples the final byte. dout is stable from that cycle until the next completed word.
- Simultaneous events: if an accepted byte and the timeout expiry fall on the same edge, the byte is accepted and the timeout does not fire.
- Back-to-back words: a byte accepted in the cycle ready is high begins the next word normally; no dead cycle is required.
- ready and err are never high in the same cycle.
- Reset mid-word: the partial word is discarded and all outputs return to their reset values immediately (asynchronous).
- Width rules: count is 4 bits and gap is 8 bits, and gap saturates at timeout. Unsigned compares only.

Test Plan:
1. nofBytes=3; send bytes A1, B2, C3, each with strobe high 1 cycle and low 1 cycle -> dout=24'hA1B2C3, ready high exactly 1 cycle, beginning the cycle after C3 is sampled; busy high from after A1 until that same edge.
2. Hold strobe high 5 cycles per byte, send 11, 22, 33 -> one word, 24'h112233, with a single ready pulse; no duplicate bytes.
3. timeout=15; send 01, 02, then no strobe -> err pulse in the cycle after the 15th edge following acceptance of 02; busy drops; dout keeps its previous value. Then send 0A, 0B, 0C -> dout=24'h0A0B0C.
4. Strobe already high when rst deasserts -> no byte accepted; after strobe falls, bytes 55, 66, 77 -> dout=24'h556677.
5. Send DE, AD, then assert rst for 1 cycle, then send 12, 34, 56 -> immediately on rst, all outputs = 0; after release dout=24'h123456, with no err pulse.
6. Two words sent back-to-back (final strobe of word 1 followed by first strobe of word 2 after 1 low cycle): CAFE01 then BEEF02 -> two ready pulses, dout=24'hCAFE01 then 24'hBEEF02; also check the last-byte/timeout coincidence at gap=timeout -> byte accepted, no err.

Source files
------------

// File: rtl/data8in_if.sv
// Byte-stream link between a byte-serial transmitter and the data8in receiver.
// Ports (signals):
//   din        : 8-bit byte data, valid while inputReady is high
//   inputReady : byte strobe, a new byte is signalled by its 0->1 transition
//   dout       : last complete assembled word, first byte in the MSBs
//   ready      : one-cycle pulse when dout has just been updated
//   busy       : high while a partial word is held
//   err        : one-cycle pulse when a partial word is abandoned on timeout
interface data8in_if #(
  parameter int nofBytes = 3
);
  logic [7:0]            din;
  logic                  inputReady;
  logic [8*nofBytes-1:0] dout;
  logic                  ready;
  logic                  busy;
  logic                  err;

  modport slave (
    input  din,
    input  inputReady,
    output dout,
    output ready,
    output busy,
    output err
  );

  modport master (
    output din,
    output inputReady,
    input  dout,
    input  ready,
    input  busy,
    input  err
  );
endinterface

// File: rtl/data8in.sv
// Byte-stream receiver: reassembles strobed 8-bit bytes into an
// nofBytes-wide word, first received byte in the MSBs, and abandons a
// partial word if the next byte does not arrive within `timeout` edges.
// Ports:
//   pclk : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : data8in_if.slave (din, inputReady in; dout, ready, busy, err out)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no partial word held; waiting for the first byte of a word
// COLLECT | 1..nofBytes-1 bytes held in the shift buffer; gap timer running
module data8in #(
  parameter int nofBytes = 3,
  parameter int timeout  = 15
) (
  input logic pclk,
  input logic rst,
  data8in_if.slave bus
);

  localparam int         WORD_W = 8 * nofBytes;
  // nofBytes=1 needs no buffer; keep a byte-wide one so widths stay legal.
  localparam int         BUF_W  = (nofBytes > 1) ? 8 * (nofBytes - 1) : 8;
  localparam logic [3:0] LAST   = 4'(nofBytes - 1);
  localparam logic [7:0] TMO    = 8'(timeout);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t             state;
  logic               hist;
  logic [3:0]         count;
  logic [7:0]         gap;
  logic [BUF_W-1:0]   buf_q;

  logic               take;
  logic               expire;
  logic [7:0]         gap_inc;
  logic [BUF_W-1:0]   buf_shift;
  logic [WORD_W-1:0]  word;

  // History resets to 1 so a strobe already high at reset release is
  // not mistaken for a new byte.
  assign take = bus.inputReady & ~hist;

  // Fires on the edge where the gap counter would reach the timeout.
  assign expire = (TMO != 8'd0) && ((gap + 8'd1) == TMO);

  // Saturate the gap counter (at timeout, or at 255 when disabled).
  always_comb begin
    gap_inc = gap + 8'd1;
    if (gap == 8'hFF)
      gap_inc = gap;
    else if ((TMO != 8'd0) && (gap == TMO))
      gap_inc = gap;
  end

  generate
    if (nofBytes == 1) begin : g_single
      assign buf_shift = bus.din;
      assign word      = bus.din;
    end else if (nofBytes == 2) begin : g_two
      assign buf_shift = bus.din;
      assign word      = {buf_q, bus.din};
    end else begin : g_multi
      assign buf_shift = {buf_q[BUF_W-9:0], bus.din};
      assign word      = {buf_q, bus.din};
    end
  endgenerate

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hist      <= 1'b1;
      count     <= 4'd0;
      gap       <= 8'd0;
      buf_q     <= '0;
      bus.dout  <= '0;
      bus.ready <= 1'b0;
      bus.busy  <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      hist      <= bus.inputReady;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            if (LAST == 4'd0) begin
              bus.dout  <= word;
              bus.ready <= 1'b1;
            end else begin
              buf_q    <= buf_shift;
              count    <= 4'd1;
              gap      <= 8'd0;
              bus.busy <= 1'b1;
              state    <= COLLECT;
            end
          end
        end
        COLLECT: begin
          // An accepted byte wins over a coincident timeout expiry.
          if (take) begin
            gap <= 8'd0;
            if (count == LAST) begin
              bus.dout  <= word;
              bus.ready <= 1'b1;
              bus.busy  <= 1'b0;
              count     <= 4'd0;
              state     <= IDLE;
            end else begin
              buf_q <= buf_shift;
              count <= count + 4'd1;
            end
          end else if (expire) begin
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            count    <= 4'd0;
            gap      <= 8'd0;
            state    <= IDLE;
          end else begin
            gap <= gap_inc;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          count    <= 4'd0;
          gap      <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data8in.sv
module tb_data8in;

  logic pclk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   ready_cnt;
  int   err_cnt;
  int   overlap_cnt;
  int   r0;
  int   e0;

  data8in_if #(.nofBytes(3)) bus ();

  data8in #(
    .nofBytes(3),
    .timeout (15)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Count pulses at the edge that ends them (values seen before the NBA update).
  always @(posedge pclk) begin
    if (bus.ready) ready_cnt++;
    if (bus.err) err_cnt++;
    if (bus.ready && bus.err) overlap_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    bus.din        = b;
    bus.inputReady = 1'b1;
    repeat (hi) @(negedge pclk);
    bus.inputReady = 1'b0;
    repeat (lo) @(negedge pclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    ready_cnt = 0; err_cnt = 0; overlap_cnt = 0;
    rst = 1'b1;
    bus.din = 8'h00;
    bus.inputReady = 1'b0;
    repeat (2) @(negedge pclk);
    chk("reset_dout", bus.dout, 24'h0);
    chk("reset_ready", bus.ready, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_err", bus.err, 1'b0);
    rst = 1'b0;
    @(negedge pclk);

    // 1: basic word, strobe 1 high / 1 low
    r0 = ready_cnt;
    send_byte(8'hA1, 1, 1);
    chk("t1_busy_after_first", bus.busy, 1'b1);
    send_byte(8'hB2, 1, 1);
    chk("t1_no_ready_mid", bus.ready, 1'b0);
    send_byte(8'hC3, 1, 0);
    chk("t1_ready", bus.ready, 1'b1);
    chk("t1_dout", bus.dout, 24'hA1B2C3);
    chk("t1_busy_done", bus.busy, 1'b0);
    bus.inputReady = 1'b0;
    @(negedge pclk);
    chk("t1_ready_one_cycle", bus.ready, 1'b0);
    chk("t1_ready_count", ready_cnt - r0, 1);

    // 2: long strobes yield one byte each
    r0 = ready_cnt;
    send_byte(8'h11, 5, 1);
    send_byte(8'h22, 5, 1);
    send_byte(8'h33, 5, 1);
    @(negedge pclk);
    chk("t2_dout", bus.dout, 24'h112233);
    chk("t2_ready_count", ready_cnt - r0, 1);
    chk("t2_busy", bus.busy, 1'b0);

    // 3: timeout after 15 idle edges following the last accepted byte
    e0 = err_cnt;
    send_byte(8'h01, 1, 1);
    send_byte(8'h02, 1, 0);
    bus.inputReady = 1'b0;
    repeat (14) @(negedge pclk);
    chk("t3_no_err_early", bus.err, 1'b0);
    chk("t3_busy_before", bus.busy, 1'b1);
    @(negedge pclk);
    chk("t3_err", bus.err, 1'b1);
    chk("t3_busy_drop", bus.busy, 1'b0);
    chk("t3_dout_kept", bus.dout, 24'h112233);
    @(negedge pclk);
    chk("t3_err_one_cycle", bus.err, 1'b0);
    chk("t3_err_count", err_cnt - e0, 1);
    send_byte(8'h0A, 1, 1);
    send_byte(8'h0B, 1, 1);
    send_byte(8'h0C, 1, 1);
    chk("t3_dout_after", bus.dout, 24'h0A0B0C);

    // 4: strobe already high at reset release is not a byte
    r0 = ready_cnt;
    bus.din = 8'h99;
    bus.inputReady = 1'b1;
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    repeat (4) @(negedge pclk);
    chk("t4_busy_held_strobe", bus.busy, 1'b0);
    chk("t4_dout_reset", bus.dout, 24'h0);
    bus.inputReady = 1'b0;
    @(negedge pclk);
    send_byte(8'h55, 1, 1);
    send_byte(8'h66, 1, 1);
    send_byte(8'h77, 1, 1);
    chk("t4_dout", bus.dout, 24'h556677);
    chk("t4_ready_count", ready_cnt - r0, 1);

    // 5: async reset mid-word
    e0 = err_cnt;
    send_byte(8'hDE, 1, 1);
    send_byte(8'hAD, 1, 1);
    chk("t5_busy_mid", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_dout", bus.dout, 24'h0);
    chk("t5_rst_busy", bus.busy, 1'b0);
    chk("t5_rst_ready", bus.ready, 1'b0);
    @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    send_byte(8'h12, 1, 1);
    send_byte(8'h34, 1, 1);
    send_byte(8'h56, 1, 1);
    chk("t5_dout", bus.dout, 24'h123456);
    chk("t5_no_err", err_cnt - e0, 0);

    // 6: back-to-back words, then byte coinciding with timeout expiry
    r0 = ready_cnt;
    send_byte(8'hCA, 1, 1);
    send_byte(8'hFE, 1, 1);
    send_byte(8'h01, 1, 0);
    chk("t6_ready1", bus.ready, 1'b1);
    chk("t6_dout1", bus.dout, 24'hCAFE01);
    bus.inputReady = 1'b0;
    @(negedge pclk);
    send_byte(8'hBE, 1, 1);
    send_byte(8'hEF, 1, 1);
    send_byte(8'h02, 1, 0);
    chk("t6_ready2", bus.ready, 1'b1);
    chk("t6_dout2", bus.dout, 24'hBEEF02);
    bus.inputReady = 1'b0;
    @(negedge pclk);
    chk("t6_ready_count", ready_cnt - r0, 2);

    e0 = err_cnt;
    send_byte(8'h33, 1, 0);
    bus.inputReady = 1'b0;
    repeat (14) @(negedge pclk);
    send_byte(8'h44, 1, 0);
    chk("t6_coinc_no_err", bus.err, 1'b0);
    chk("t6_coinc_busy", bus.busy, 1'b1);
    bus.inputReady = 1'b0;
    @(negedge pclk);
    send_byte(8'h55, 1, 1);
    chk("t6_coinc_dout", bus.dout, 24'h334455);
    chk("t6_coinc_err_count", err_cnt - e0, 0);

    @(negedge pclk);
    chk("ready_err_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
